rom_dumper: RTL and testbench

Read-back path for instruction memory: on a start pulse it walks `WORDS` consecutive words of the ROM read port and serialises each word as four 8N1 UART bytes on a TX line. It is the transmit-side counterpart of the UART-to-ROM loader, and lets the host verify a programmed image over the same serial link. It runs on the board clock, beside the loader, and drives a second ROM read address when the CPU is held.

---
 rtl/rom_dumper_pkg.sv | 21 ++
 rtl/rom_dumper_uart_tx.sv | 100 ++++++++++
 rtl/rom_dumper.sv | 117 +++++++++++
 tb/tb_rom_dumper.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_dumper_pkg.sv
// Shared FSM encodings and UART framing constant for the ROM read-back path.
package rom_dumper_pkg;

  // Start bit + 8 data bits + stop bit.
  localparam int unsigned UART_FRAME_BITS = 10;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StLoad,
    StSend
  } dump_state_e;

  typedef enum logic [1:0] {
    TxIdle,
    TxStart,
    TxData,
    TxStop
  } tx_state_e;

endpackage

// File: rtl/rom_dumper_uart_tx.sv
// 8N1 UART transmitter: one byte per tx_dv pulse, tx_done on the last clock of the stop bit.
module rom_dumper_uart_tx
  import rom_dumper_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 87
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_dv,
  input  logic [7:0] tx_byte,
  output logic       tx_serial,
  output logic       tx_active,
  output logic       tx_done
);

  localparam int unsigned TimerW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TimerW-1:0] BitLast = TimerW'(CLKS_PER_BIT - 1);

  tx_state_e         state_q, state_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [7:0]        data_q, data_d;

  // Next-state: each non-idle state holds for CLKS_PER_BIT clocks per bit.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    bit_idx_d = bit_idx_q;
    data_d    = data_q;
    tx_done   = 1'b0;
    case (state_q)
      TxIdle: begin
        timer_d   = '0;
        bit_idx_d = '0;
        if (tx_dv) begin
          data_d  = tx_byte;
          state_d = TxStart;
        end
      end
      TxStart: begin
        if (timer_q == BitLast) begin
          timer_d = '0;
          state_d = TxData;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      TxData: begin
        if (timer_q == BitLast) begin
          timer_d = '0;
          if (bit_idx_q == 3'd7) begin
            state_d = TxStop;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      TxStop: begin
        if (timer_q == BitLast) begin
          timer_d = '0;
          tx_done = 1'b1;
          state_d = TxIdle;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = TxIdle;
    endcase
  end

  // Line level decoded from state; idle and stop are both high.
  always_comb begin
    tx_serial = 1'b1;
    case (state_q)
      TxStart: tx_serial = 1'b0;
      TxData:  tx_serial = data_q[bit_idx_q];
      default: tx_serial = 1'b1;
    endcase
  end

  assign tx_active = (state_q != TxIdle);

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= TxIdle;
      timer_q   <= '0;
      bit_idx_q <= '0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_idx_q <= bit_idx_d;
      data_q    <= data_d;
    end
  end

endmodule

// File: rtl/rom_dumper.sv
// Walks WORDS ROM words on a start pulse and sends each as four little-endian UART bytes.
module rom_dumper
  import rom_dumper_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 87,
  parameter int unsigned WORDS        = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [31:0] ra,
  input  logic [31:0] rd,
  output logic        uart_tx,
  output logic        busy,
  output logic        done
);

  localparam int unsigned WordW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [WordW-1:0] WordLast = WordW'(WORDS - 1);

  dump_state_e      state_q, state_d;
  logic [WordW-1:0] word_cnt_q, word_cnt_d;
  logic [1:0]       byte_cnt_q, byte_cnt_d;
  logic [31:0]      word_q, word_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             tx_dv_q, tx_dv_d;

  logic       tx_done;
  logic       unused_tx_active;
  logic [7:0] tx_byte;

  // Byte counter selects the slice; byte 0 is rd[7:0].
  assign tx_byte = word_q[{byte_cnt_q, 3'b000} +: 8];

  // Dump sequencer: READ gives the ROM a clock, LOAD captures, SEND paces bytes on tx_done.
  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    byte_cnt_d = byte_cnt_q;
    word_d     = word_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    tx_dv_d    = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          busy_d     = 1'b1;
          word_cnt_d = '0;
          state_d    = StRead;
        end
      end
      StRead: state_d = StLoad;
      StLoad: begin
        word_d     = rd;
        byte_cnt_d = 2'd0;
        tx_dv_d    = 1'b1;
        state_d    = StSend;
      end
      StSend: begin
        if (tx_done) begin
          if (byte_cnt_q != 2'd3) begin
            byte_cnt_d = byte_cnt_q + 1'b1;
            tx_dv_d    = 1'b1;
          end else if (word_cnt_q != WordLast) begin
            word_cnt_d = word_cnt_q + 1'b1;
            state_d    = StRead;
          end else begin
            word_cnt_d = '0;
            busy_d     = 1'b0;
            done_d     = 1'b1;
            state_d    = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      word_cnt_q <= '0;
      byte_cnt_q <= '0;
      word_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      tx_dv_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      word_q     <= word_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      tx_dv_q    <= tx_dv_d;
    end
  end

  rom_dumper_uart_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart_tx (
    .clk      (clk),
    .rst_n    (rst_n),
    .tx_dv    (tx_dv_q),
    .tx_byte  (tx_byte),
    .tx_serial(uart_tx),
    .tx_active(unused_tx_active),
    .tx_done  (tx_done)
  );

  assign ra   = 32'(word_cnt_q);
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_rom_dumper.sv
// Self-checking bench: three dumper configurations against a timeline model of a dump.
module tb_rom_dumper;
  import rom_dumper_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        start_w[3];
  logic [31:0] ra_w[3];
  logic [31:0] rd_w[3];
  logic        tx_w[3];
  logic        busy_w[3];
  logic        done_w[3];
  logic [31:0] rom[3][4];

  int cpb[3]    = '{4, 4, 87};
  int nwords[3] = '{1, 3, 2};

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Model state: accepting edge index and ROM snapshot per instance.
  int          t0[3];
  bit          running[3];
  logic [31:0] snap[3][4];

  // Monitors.
  int          done_cnt[3];
  int          rx_ph[3];
  logic [7:0]  rx_sh[3];
  logic [7:0]  rxb[3][16];
  int          rxn[3];
  bit          rl_en;
  bit          rl_first;
  logic        rl_last;
  int          rl_run;
  int          n_low, n_low_bad, n_h87, n_h88, n_h90, n_hother;

  rom_dumper #(.CLKS_PER_BIT(4), .WORDS(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start_w[0]), .ra(ra_w[0]), .rd(rd_w[0]),
    .uart_tx(tx_w[0]), .busy(busy_w[0]), .done(done_w[0])
  );
  rom_dumper #(.CLKS_PER_BIT(4), .WORDS(3)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_w[1]), .ra(ra_w[1]), .rd(rd_w[1]),
    .uart_tx(tx_w[1]), .busy(busy_w[1]), .done(done_w[1])
  );
  rom_dumper #(.CLKS_PER_BIT(87), .WORDS(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start_w[2]), .ra(ra_w[2]), .rd(rd_w[2]),
    .uart_tx(tx_w[2]), .busy(busy_w[2]), .done(done_w[2])
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  // Clocks per byte slot (frame + handoff) and per word (slot*4 + READ + LOAD).
  function automatic int slot_len(input int i);
    return int'(UART_FRAME_BITS) * cpb[i] + 1;
  endfunction

  function automatic int word_len(input int i);
    return 2 + 4 * slot_len(i);
  endfunction

  // Expected {uart_tx, busy, done, ra} k clocks after the accepting edge.
  function automatic logic [34:0] model_out(input int i, input int k);
    int   c, fr, p, r, b, q, bi;
    logic [7:0] by;
    logic tx;
    c  = cpb[i];
    fr = slot_len(i);
    p  = word_len(i);
    if (!running[i] || k < 0 || k > nwords[i] * p) return {3'b100, 32'd0};
    if (k == nwords[i] * p) return {3'b101, 32'd0};
    r  = k % p;
    tx = 1'b1;
    if (r >= 3) begin
      b = (r - 3) / fr;
      q = (r - 3) % fr;
      if (q < fr - 1) begin
        bi = q / c;
        by = 8'(snap[i][k/p] >> (8 * b));
        if (bi == 0) tx = 1'b0;
        else if (bi <= 8) tx = by[bi-1];
      end
    end
    return {tx, 2'b10, 32'(k / p)};
  endfunction

  // Registered ROM read port.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) rd_w[i] <= rom[i][ra_w[i][1:0]];
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Model acceptance: start honoured only when the model says the dumper is idle.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) running[i] <= 1'b0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (start_w[i] && !(running[i] && (cyc - t0[i]) < nwords[i] * word_len(i))) begin
          t0[i]      <= cyc + 1;
          running[i] <= 1'b1;
          for (int j = 0; j < 4; j++) snap[i][j] <= rom[i][j];
        end
      end
    end
  end

  // Per-cycle compare plus line monitors.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      logic [34:0] e;
      e = (!rst_n) ? {3'b100, 32'd0} : model_out(i, cyc - t0[i]);
      check($sformatf("tx%0d@%0d", i, cyc), {31'd0, tx_w[i]}, {31'd0, e[34]});
      check($sformatf("busy%0d@%0d", i, cyc), {31'd0, busy_w[i]}, {31'd0, e[33]});
      check($sformatf("done%0d@%0d", i, cyc), {31'd0, done_w[i]}, {31'd0, e[32]});
      check($sformatf("ra%0d@%0d", i, cyc), ra_w[i], e[31:0]);
      if (done_w[i] === 1'b1) done_cnt[i]++;
    end
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        rx_ph[i] = -1;
      end else if (rx_ph[i] < 0) begin
        if (tx_w[i] == 1'b0) rx_ph[i] = 0;
      end else begin
        rx_ph[i]++;
        if (rx_ph[i] == 9 * cpb[i] + cpb[i] / 2) begin
          if (rxn[i] < 16) rxb[i][rxn[i]] = rx_sh[i];
          rxn[i]++;
          rx_ph[i] = -1;
        end else if (rx_ph[i] % cpb[i] == cpb[i] / 2) begin
          rx_sh[i] = {tx_w[i], rx_sh[i][7:1]};
        end
      end
    end
    if (!rl_en) begin
      rl_last  = 1'b1;
      rl_run   = 0;
      rl_first = 1'b1;
    end else if (tx_w[2] == rl_last) begin
      rl_run++;
    end else begin
      if (rl_last) begin
        if (!rl_first) begin
          if (rl_run == 87) n_h87++;
          else if (rl_run == 88) n_h88++;
          else if (rl_run == 90) n_h90++;
          else n_hother++;
        end
        rl_first = 1'b0;
      end else begin
        n_low++;
        if (rl_run != 87) n_low_bad++;
      end
      rl_last = tx_w[2];
      rl_run  = 1;
    end
  end

  task automatic pulse(input int i, output int acc);
    @(negedge clk);
    start_w[i] = 1'b1;
    @(negedge clk);
    acc        = cyc;
    start_w[i] = 1'b0;
  endtask

  task automatic wait_done(input int i, input int limit);
    int n = 0;
    while (done_w[i] !== 1'b1 && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (done_w[i] !== 1'b1) check($sformatf("done_timeout%0d", i), {31'd0, done_w[i]}, 32'd1);
  endtask

  initial begin
    int acc, acc2, dc, n, k;
    logic [7:0] exp12[12];
    exp12 = '{8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h00, 8'h00, 8'h00, 8'h00,
              8'hFF, 8'hFF, 8'hFF, 8'hFF};
    rst_n = 1'b0;
    rl_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      start_w[i] = 1'b0;
      rxn[i] = 0;
      done_cnt[i] = 0;
      for (int j = 0; j < 4; j++) rom[i][j] = 32'd0;
    end
    n_low = 0; n_low_bad = 0; n_h87 = 0; n_h88 = 0; n_h90 = 0; n_hother = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_tx", {31'd0, tx_w[1]}, 32'd1);
    check("reset_busy", {31'd0, busy_w[1]}, 32'd0);

    // Single word, literal latency and bytes.
    rom[0][0] = 32'h1234_5678;
    rxn[0] = 0;
    pulse(0, acc);
    wait_done(0, 400);
    check("single_done_latency", cyc - acc + 1, 32'd167);
    @(negedge clk);
    check("single_nbytes", rxn[0], 32'd4);
    check("single_b0", {24'd0, rxb[0][0]}, 32'h78);
    check("single_b1", {24'd0, rxb[0][1]}, 32'h56);
    check("single_b2", {24'd0, rxb[0][2]}, 32'h34);
    check("single_b3", {24'd0, rxb[0][3]}, 32'h12);
    check("single_ra_after", ra_w[0], 32'd0);

    // Busy rejection: extra start pulses at clocks 50 and 100.
    rom[0][0] = $urandom;
    rxn[0] = 0;
    dc = done_cnt[0];
    pulse(0, acc);
    for (int m = 2; m <= 110; m++) begin
      @(negedge clk);
      start_w[0] = (m == 50 || m == 100);
    end
    start_w[0] = 1'b0;
    wait_done(0, 400);
    repeat (200) @(negedge clk);
    check("busy_rej_nbytes", rxn[0], 32'd4);
    check("busy_rej_ndone", done_cnt[0] - dc, 32'd1);

    // Multi-word little-endian order.
    rom[1][0] = 32'hDEAD_BEEF; rom[1][1] = 32'h0; rom[1][2] = 32'hFFFF_FFFF;
    rxn[1] = 0;
    dc = done_cnt[1];
    pulse(1, acc);
    wait_done(1, 800);
    repeat (3) @(negedge clk);
    check("multi_nbytes", rxn[1], 32'd12);
    for (int b = 0; b < 12; b++) check($sformatf("multi_b%0d", b), {24'd0, rxb[1][b]},
                                       {24'd0, exp12[b]});
    check("multi_ndone", done_cnt[1] - dc, 32'd1);

    // Restart in the done clock: line low three clocks after acceptance.
    pulse(1, acc);
    wait_done(1, 800);
    start_w[1] = 1'b1;
    @(negedge clk);
    acc2 = cyc;
    start_w[1] = 1'b0;
    n = 0;
    while (tx_w[1] !== 1'b0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("restart_low_delay", cyc - acc2, 32'd3);
    wait_done(1, 800);
    repeat (3) @(negedge clk);

    // Asynchronous reset during data bit 3 of byte 1 (byte 0xF0, bit 3 low).
    rom[1][0] = 32'hA5A5_F0F0; rom[1][1] = $urandom; rom[1][2] = $urandom;
    pulse(1, acc);
    while (cyc < acc + 61) @(negedge clk);
    check("pre_reset_tx", {31'd0, tx_w[1]}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("mid_reset_tx", {31'd0, tx_w[1]}, 32'd1);
    check("mid_reset_busy", {31'd0, busy_w[1]}, 32'd0);
    check("mid_reset_ra", ra_w[1], 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rxn[1] = 0;
    pulse(1, acc);
    wait_done(1, 800);
    repeat (3) @(negedge clk);
    check("post_reset_nbytes", rxn[1], 32'd12);
    check("post_reset_b0", {24'd0, rxb[1][0]}, 32'hF0);
    check("post_reset_b2", {24'd0, rxb[1][2]}, 32'hA5);

    // Randomized starts and ROM rewrites of words already captured.
    for (int j = 0; j < 3; j++) rom[1][j] = $urandom;
    rom[0][0] = $urandom;
    for (int m = 0; m < 3000; m++) begin
      @(negedge clk);
      start_w[0] = ($urandom_range(0, 99) < 3);
      start_w[1] = ($urandom_range(0, 99) < 3);
      if (running[1]) begin
        k = cyc - t0[1];
        if (k >= 0 && k < 3 * word_len(1) && (k % word_len(1)) >= 3 &&
            $urandom_range(0, 99) < 5) rom[1][k/word_len(1)] = $urandom;
      end
      if ($urandom_range(0, 99) < 2 && !(running[0] && (cyc - t0[0]) <= word_len(0)))
        rom[0][0] = $urandom;
    end
    start_w[0] = 1'b0;
    start_w[1] = 1'b0;
    n = 0;
    while ((busy_w[0] !== 1'b0 || busy_w[1] !== 1'b0) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("random_drain", {30'd0, busy_w[1], busy_w[0]}, 32'd0);

    // Bit timing at 87 clocks per bit.
    rom[2][0] = 32'h5555_5555; rom[2][1] = 32'h5555_5555;
    @(negedge clk);
    rl_en = 1'b1;
    pulse(2, acc);
    wait_done(2, 8000);
    @(negedge clk);
    rl_en = 1'b0;
    check("timing_low_runs", n_low, 32'd40);
    check("timing_low_bad", n_low_bad, 32'd0);
    check("timing_high_87", n_h87, 32'd32);
    check("timing_gap_byte", n_h88, 32'd6);
    check("timing_gap_word", n_h90, 32'd1);
    check("timing_high_other", n_hother, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
